call_request_latch: RTL and testbench
=====================================

// Module: call_request_latch
// PURPOSE
//  Front end of the elevator controller. Synchronises and debounces the 13 raw
//  buttons (hall up u1..u4, hall down d2..d5, car target1..target5), then latches
//  each press as a pending request until the car services it. Pending vectors
//  feed the controller's request inputs; the controller's floor/direction/door
//  state feeds back here to clear serviced requests.
// PARAMETERS
//  DEB_CYCLES  1_000_000  consecutive stable cycles before a debounced level changes (10 ms @ 100 MHz); >=2
//  CNT_W       20         debounce counter width; must hold DEB_CYCLES-1
// PORTS
//  clk          in   1  system clock, single clock domain
//  RESET        in   1  synchronous, active-low reset
//  up_btn       in   4  raw hall-up buttons, bit k = floor k+1 (u1..u4), async
//  dn_btn       in   4  raw hall-down buttons, bit k = floor k+2 (d2..d5), async
//  car_btn      in   5  raw car buttons, bit k = floor k+1 (target1..5), async
//  car_floor    in   5  one-hot current floor, bit k = floor k+1
//  moving_up    in   1  car travelling up
//  moving_dn    in   1  car travelling down
//  door_open    in   1  door open at car_floor (service point)
//  up_req       out  4  pending hall-up requests
//  dn_req       out  4  pending hall-down requests
//  car_req      out  5  pending car requests
//  any_req      out  1  OR of all pending bits
//  new_req      out  1  1-cycle pulse: at least one pending bit set this edge
//  floor_err    out  1  car_floor not exactly one-hot (registered)
// BEHAVIOUR
//  - Reset (RESET=0 at an edge): all sync/debounce state 0, all counters 0, every
//    output 0. Reset mid-debounce or with requests pending discards everything.
//  - Per button: 2-FF synchroniser -> debouncer -> rising-edge detect. 13 identical lanes.
//  - Debouncer: counter clears when sync==deb; else increments. On the edge where
//    sync!=deb and cnt==DEB_CYCLES-1, deb<=sync, cnt<=0. Glitch shorter than
//    DEB_CYCLES cycles never changes deb.
//  - Latency: raw held high from before edge 0 -> sync high after edge 2 ->
//    deb high after edge 2+DEB_CYCLES -> pending bit high after edge 3+DEB_CYCLES.
//  - Set: deb rising edge sets the lane's pending bit. Holding a button sets once;
//    release+re-press needed to re-request. Already-pending bit: no change, no pulse.
//  - Service (only when door_open=1 and car_floor one-hot, floor f):
//    car_req[f] cleared; up_req[f] cleared if !moving_dn; dn_req[f] cleared if
//    !moving_up. Floors with no such button (up at 5, down at 1) ignored.
//  - Set and clear of same bit on same edge: clear wins, new_req not pulsed for it.
//  - Press at the floor being serviced with matching direction: never latched.
//  - car_floor zero or multi-hot: no clears that edge, floor_err=1 next cycle.
//  - moving_up and moving_dn both 1: treated as stopped only for clearing? No:
//    clears neither hall bit; car_req still cleared.
//  - any_req, new_req, floor_err registered; new_req aligns with the set edge.
// TESTING (bench uses DEB_CYCLES=4)
//  1 Reset: RESET=0 two cycles with buttons held -> all outputs 0; release RESET,
//    held car_btn[2] -> car_req=5'b00100 exactly 7 edges later, new_req 1 cycle.
//  2 Glitch: up_btn[0] high 3 cycles then low -> up_req stays 0, new_req never pulses.
//  3 Service: car_req=5'b01000, up_req[3]=1, dn_req[2]=1 (floor 4); car_floor=5'b01000,
//    door_open=1, moving_up=1 -> car_req[3],up_req[3] clear next edge; dn_req[2] stays.
//  4 Collision: door_open=1 at floor 2 stopped while car_btn[1] debounces high ->
//    car_req[1] stays 0, new_req 0.
//  5 Hold/re-press: dn_btn[1] held 20 cycles -> one set, one pulse; service clears;
//    release 5 cycles, re-press -> sets again with second pulse.
//  6 Bad floor: car_floor=5'b00110, door_open=1 with pending bits -> none cleared,
//    floor_err=1; car_floor=5'b00010 -> floor_err=0 next cycle, floor 2 clears.

Source files
------------

// File: rtl/call_request_latch.sv
// call_request_latch: elevator button front end.
// Each raw button is synchronised, debounced and edge-detected, then held as a
// pending request until the car services it at the matching floor/direction.
// A pending bit is set by a debounced press and cleared when the door is open at
// that floor. If a set and a clear hit the same bit on the same edge, the clear wins.

module crl_debounce_lane #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb,
  output logic rise
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             deb_q;
  logic             deb_prev;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser, then a debouncer that flips only after DEB_CYCLES
  // consecutive edges of disagreement between the synced input and the debounced level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      deb_q    <= 1'b0;
      deb_prev <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb_q;
      if (sync2 == deb_q) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        deb_q <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign deb  = deb_q;
  // A rising edge of the debounced level is a press.
  assign rise = deb_q & ~deb_prev;

endmodule

module call_request_latch #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [3:0] up_btn,
  input  logic [3:0] dn_btn,
  input  logic [4:0] car_btn,
  input  logic [4:0] car_floor,
  input  logic       moving_up,
  input  logic       moving_dn,
  input  logic       door_open,
  output logic [3:0] up_req,
  output logic [3:0] dn_req,
  output logic [4:0] car_req,
  output logic       any_req,
  output logic       new_req,
  output logic       floor_err
);

  // Lane packing: [3:0] hall up (floors 1..4), [7:4] hall down (floors 2..5),
  // [12:8] car buttons (floors 1..5).
  logic [12:0] raw_all;
  logic [12:0] deb_all;
  logic [12:0] rise_all;

  assign raw_all = {car_btn, dn_btn, up_btn};

  genvar g;
  generate
    for (g = 0; g < 13; g++) begin : g_lane
      crl_debounce_lane #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
      ) u_lane (
        .clk   (clk),
        .rst_n (RESET),
        .raw   (raw_all[g]),
        .deb   (deb_all[g]),
        .rise  (rise_all[g])
      );
    end
  endgenerate

  logic [3:0] rise_up;
  logic [3:0] rise_dn;
  logic [4:0] rise_car;

  assign rise_up  = rise_all[3:0];
  assign rise_dn  = rise_all[7:4];
  assign rise_car = rise_all[12:8];

  // Service decode: clears only happen with the door open at a single valid floor.
  logic       floor_ok;
  logic       svc;
  logic [3:0] clr_up;
  logic [3:0] clr_dn;
  logic [4:0] clr_car;

  always_comb begin
    floor_ok = (car_floor != 5'd0) && ((car_floor & (car_floor - 5'd1)) == 5'd0);
    svc      = door_open & floor_ok;
    clr_car  = 5'd0;
    clr_up   = 4'd0;
    clr_dn   = 4'd0;
    if (svc) begin
      clr_car = car_floor;
      // Up buttons exist on floors 1..4; floor 5 has none, so car_floor[4] is dropped.
      if (!moving_dn) clr_up = car_floor[3:0];
      // Down buttons exist on floors 2..5; floor 1 has none, so car_floor[0] is dropped.
      if (!moving_up) clr_dn = car_floor[4:1];
    end
  end

  // Next pending state and the "something newly latched" flag.
  logic [3:0] up_nxt;
  logic [3:0] dn_nxt;
  logic [4:0] car_nxt;
  logic       set_any;

  always_comb begin
    up_nxt  = (up_req  | rise_up)  & ~clr_up;
    dn_nxt  = (dn_req  | rise_dn)  & ~clr_dn;
    car_nxt = (car_req | rise_car) & ~clr_car;
    // Only a bit that was idle, is pressed, and survives the clear counts as new.
    set_any = |(rise_up  & ~up_req  & ~clr_up)
            | |(rise_dn  & ~dn_req  & ~clr_dn)
            | |(rise_car & ~car_req & ~clr_car);
  end

  // Pending registers and registered status flags, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      up_req    <= 4'd0;
      dn_req    <= 4'd0;
      car_req   <= 5'd0;
      any_req   <= 1'b0;
      new_req   <= 1'b0;
      floor_err <= 1'b0;
    end else begin
      up_req    <= up_nxt;
      dn_req    <= dn_nxt;
      car_req   <= car_nxt;
      any_req   <= (|up_nxt) | (|dn_nxt) | (|car_nxt);
      new_req   <= set_any;
      floor_err <= ~floor_ok;
    end
  end

endmodule

// File: tb/tb_call_request_latch.sv
// Directed bench for call_request_latch with a short debounce window.
module tb_call_request_latch;

  localparam int DEB = 4;

  logic       clk;
  logic       RESET;
  logic [3:0] up_btn;
  logic [3:0] dn_btn;
  logic [4:0] car_btn;
  logic [4:0] car_floor;
  logic       moving_up;
  logic       moving_dn;
  logic       door_open;
  logic [3:0] up_req;
  logic [3:0] dn_req;
  logic [4:0] car_req;
  logic       any_req;
  logic       new_req;
  logic       floor_err;

  int n_checks;
  int n_fail;
  int pulses;

  call_request_latch #(
    .DEB_CYCLES (DEB),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .up_btn    (up_btn),
    .dn_btn    (dn_btn),
    .car_btn   (car_btn),
    .car_floor (car_floor),
    .moving_up (moving_up),
    .moving_dn (moving_dn),
    .door_open (door_open),
    .up_req    (up_req),
    .dn_req    (dn_req),
    .car_req   (car_req),
    .any_req   (any_req),
    .new_req   (new_req),
    .floor_err (floor_err)
  );

  // Clock and reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    up_btn    = 4'd0;
    dn_btn    = 4'd0;
    car_btn   = 5'd0;
    car_floor = 5'b00001;
    moving_up = 1'b0;
    moving_dn = 1'b0;
    door_open = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // 1: reset with everything held, then a single held car button.
    RESET     = 1'b0;
    up_btn    = 4'hf;
    dn_btn    = 4'hf;
    car_btn   = 5'h1f;
    car_floor = 5'b00110;
    door_open = 1'b1;
    moving_up = 1'b0;
    moving_dn = 1'b0;
    tick();
    tick();
    check("t1 rst up_req", up_req, 0);
    check("t1 rst dn_req", dn_req, 0);
    check("t1 rst car_req", car_req, 0);
    check("t1 rst any_req", any_req, 0);
    check("t1 rst new_req", new_req, 0);
    check("t1 rst floor_err", floor_err, 0);
    idle_inputs();
    car_btn = 5'b00100;
    RESET   = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("t1 early car_req", car_req, 0);
      check("t1 early new_req", new_req, 0);
    end
    tick();
    check("t1 edge7 car_req", car_req, 5'b00100);
    check("t1 edge7 new_req", new_req, 1);
    check("t1 edge7 any_req", any_req, 1);
    check("t1 edge7 floor_err", floor_err, 0);
    tick();
    check("t1 edge8 new_req", new_req, 0);
    check("t1 edge8 car_req", car_req, 5'b00100);

    // 2: three-cycle glitch is rejected.
    do_reset();
    up_btn = 4'b0001;
    tick();
    tick();
    tick();
    up_btn = 4'b0000;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (new_req === 1'b1) pulses++;
      check("t2 up_req", up_req, 0);
    end
    check("t2 pulses", pulses, 0);

    // 3: service at floor 4 while moving up.
    do_reset();
    car_btn = 5'b01000;
    up_btn  = 4'b1000;
    dn_btn  = 4'b0100;
    repeat (6) tick();
    check("t3 pre car_req", car_req, 0);
    tick();
    check("t3 set car_req", car_req, 5'b01000);
    check("t3 set up_req", up_req, 4'b1000);
    check("t3 set dn_req", dn_req, 4'b0100);
    check("t3 set new_req", new_req, 1);
    car_btn   = 5'd0;
    up_btn    = 4'd0;
    dn_btn    = 4'd0;
    car_floor = 5'b01000;
    door_open = 1'b1;
    moving_up = 1'b1;
    tick();
    check("t3 svc car_req", car_req, 0);
    check("t3 svc up_req", up_req, 0);
    check("t3 svc dn_req", dn_req, 4'b0100);
    check("t3 svc any_req", any_req, 1);
    check("t3 svc new_req", new_req, 0);

    // 4: press at the floor being serviced is never latched.
    do_reset();
    car_floor = 5'b00010;
    door_open = 1'b1;
    car_btn   = 5'b00010;
    pulses    = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (new_req === 1'b1) pulses++;
      check("t4 car_req", car_req, 0);
    end
    door_open = 1'b0;
    repeat (3) tick();
    check("t4 after door car_req", car_req, 0);
    check("t4 pulses", pulses, 0);

    // 5: long hold sets once; release and re-press sets again.
    do_reset();
    dn_btn = 4'b0010;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (new_req === 1'b1) pulses++;
    end
    check("t5 hold pulses", pulses, 1);
    check("t5 hold dn_req", dn_req, 4'b0010);
    car_floor = 5'b00100;
    door_open = 1'b1;
    tick();
    check("t5 svc dn_req", dn_req, 0);
    check("t5 svc any_req", any_req, 0);
    door_open = 1'b0;
    car_floor = 5'b00001;
    dn_btn    = 4'b0000;
    repeat (5) tick();
    dn_btn = 4'b0010;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (new_req === 1'b1) pulses++;
    end
    check("t5 repress pulses", pulses, 1);
    check("t5 repress dn_req", dn_req, 4'b0010);

    // 6: multi-hot floor blocks clears; valid floor then clears floor 2.
    do_reset();
    car_btn = 5'b00110;
    up_btn  = 4'b0010;
    dn_btn  = 4'b0010;
    repeat (7) tick();
    check("t6 set car_req", car_req, 5'b00110);
    check("t6 set up_req", up_req, 4'b0010);
    check("t6 set dn_req", dn_req, 4'b0010);
    car_btn   = 5'd0;
    up_btn    = 4'd0;
    dn_btn    = 4'd0;
    car_floor = 5'b00110;
    door_open = 1'b1;
    tick();
    check("t6 bad car_req", car_req, 5'b00110);
    check("t6 bad up_req", up_req, 4'b0010);
    check("t6 bad dn_req", dn_req, 4'b0010);
    check("t6 bad floor_err", floor_err, 1);
    car_floor = 5'b00010;
    tick();
    check("t6 ok floor_err", floor_err, 0);
    check("t6 ok car_req", car_req, 5'b00100);
    check("t6 ok up_req", up_req, 0);
    check("t6 ok dn_req", dn_req, 4'b0010);
    car_floor = 5'b00100;
    moving_up = 1'b1;
    moving_dn = 1'b1;
    tick();
    check("t6 both car_req", car_req, 0);
    check("t6 both dn_req", dn_req, 4'b0010);
    check("t6 both any_req", any_req, 1);
    RESET = 1'b0;
    tick();
    check("t6 rst dn_req", dn_req, 0);
    check("t6 rst any_req", any_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
